// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared widths and receive-FSM encoding for the AXIS receive buffer
package axi_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int PKT_CNT_W  = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rx_state_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy level
module axis_sync_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Ready comes only from the registered level, so a same-cycle pop never frees a slot.
    assign wr_ready = (level != LVL_W'(DEPTH));
    assign rd_valid = (level != '0);
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage has no reset; stale entries are invisible once the level clears.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/axis_rx_buffer.sv
// rtl/axis_rx_buffer.sv - AXIS receive buffer with packet tracking FSM and packet counter
module axis_rx_buffer
    import axi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                     ACLK,
    input  logic                     ARST,
    input  logic                     S_TVALID,
    input  logic [DATA_W-1:0]        S_TDATA,
    input  logic                     S_TLAST,
    output logic                     S_TREADY,
    output logic [DATA_W-1:0]        OUT_DATA,
    output logic                     OUT_LAST,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic [PKT_CNT_W-1:0]     PKT_CNT,
    output logic                     BUSY
);

    rx_state_t state;
    logic      accept;

    assign accept = S_TVALID & S_TREADY;
    assign BUSY   = (state == ST_BURST);

    axis_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (ACLK),
        .rst      (ARST),
        .wr_valid (S_TVALID),
        .wr_data  ({S_TDATA, S_TLAST}),
        .wr_ready (S_TREADY),
        .rd_data  ({OUT_DATA, OUT_LAST}),
        .rd_valid (OUT_VALID),
        .rd_ready (OUT_READY),
        .level    (LEVEL)
    );

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state   <= ST_IDLE;
            PKT_CNT <= '0;
        end else if (accept) begin
            if (S_TLAST) begin
                state   <= ST_IDLE;
                PKT_CNT <= PKT_CNT + PKT_CNT_W'(1);
            end else begin
                state   <= ST_BURST;
            end
        end
    end

endmodule

// File: tb/tb_axis_rx_buffer.sv
// tb/tb_axis_rx_buffer.sv - directed table-driven bench for axis_rx_buffer
module tb_axis_rx_buffer;

    logic        clk = 1'b0;
    logic        arst;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic [15:0] pkt_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_rx_buffer #(.DATA_W(32), .DEPTH(4)) dut (
        .ACLK      (clk),
        .ARST      (arst),
        .S_TVALID  (s_tvalid),
        .S_TDATA   (s_tdata),
        .S_TLAST   (s_tlast),
        .S_TREADY  (s_tready),
        .OUT_DATA  (out_data),
        .OUT_LAST  (out_last),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .LEVEL     (level),
        .PKT_CNT   (pkt_cnt),
        .BUSY      (busy)
    );

    typedef struct {
        logic        tv;
        logic [31:0] td;
        logic        tl;
        logic        ordy;
        logic [2:0]  lvl;
        logic        trdy;
        logic        ov;
        logic [31:0] od;
        logic        ol;
        logic        bsy;
        logic [15:0] pkt;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic tv, input logic [31:0] td, input logic tl, input logic ordy);
        s_tvalid  = tv;
        s_tdata   = td;
        s_tlast   = tl;
        out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        arst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " level"}, 32'(level), 32'd0);
        chk({tag, " tready"}, 32'(s_tready), 32'd1);
        chk({tag, " valid"}, 32'(out_valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " pkt"}, 32'(pkt_cnt), 32'd0);
    endtask

    initial begin
        //            tv    td          tl    ordy  lvl  trdy  ov    od          ol    bsy   pkt
        vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 16'd0};
        vecs[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 16'd0};
        vecs[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 16'd0};
        vecs[3]  = '{1'b1, 32'h44, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 16'd1};
        vecs[4]  = '{1'b1, 32'h55, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 32'h22, 1'b0, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 16'd1};
        vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 16'd1};
        vecs[8]  = '{1'b1, 32'h61, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h61, 1'b0, 1'b1, 16'd1};
        vecs[9]  = '{1'b1, 32'h62, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h61, 1'b0, 1'b1, 16'd1};
        vecs[10] = '{1'b1, 32'h63, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h61, 1'b0, 1'b1, 16'd1};
        vecs[11] = '{1'b1, 32'h64, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 32'h61, 1'b0, 1'b0, 16'd2};
        vecs[12] = '{1'b1, 32'hEE, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 32'h61, 1'b0, 1'b0, 16'd2};
        vecs[13] = '{1'b0, 32'hDD, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 32'h61, 1'b0, 1'b0, 16'd2};
        vecs[14] = '{1'b1, 32'hCC, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 32'h61, 1'b0, 1'b0, 16'd2};
        vecs[15] = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 32'h62, 1'b0, 1'b0, 16'd2};
        vecs[16] = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 32'h63, 1'b0, 1'b0, 16'd2};
        vecs[17] = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h64, 1'b1, 1'b0, 16'd2};
        vecs[18] = '{1'b0, 32'h0,  1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 16'd2};

        arst = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        do_reset();
        chk_idle("reset");

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].tv, vecs[i].td, vecs[i].tl, vecs[i].ordy);
            chk($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].lvl));
            chk($sformatf("v%0d tready", i), 32'(s_tready), 32'(vecs[i].trdy));
            chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("v%0d pkt", i), 32'(pkt_cnt), 32'(vecs[i].pkt));
            if (vecs[i].ov) begin
                chk($sformatf("v%0d data", i), out_data, vecs[i].od);
                chk($sformatf("v%0d last", i), 32'(out_last), 32'(vecs[i].ol));
            end
        end

        // streaming: 16 beats through a one-deep steady state, last beat closes the packet
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h100 + 32'(i), (i == 15), 1'b1);
            chk($sformatf("stream%0d level", i), 32'(level), 32'd1);
            chk($sformatf("stream%0d data", i), out_data, 32'h100 + 32'(i));
        end
        chk("stream busy", 32'(busy), 32'd0);
        chk("stream pkt", 32'(pkt_cnt), 32'd3);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("stream drained", 32'(level), 32'd0);

        // reset mid-packet with a beat offered and a pop requested in the reset cycle
        step(1'b1, 32'hA0, 1'b0, 1'b0);
        step(1'b1, 32'hA1, 1'b0, 1'b0);
        chk("pre-reset level", 32'(level), 32'd2);
        chk("pre-reset busy", 32'(busy), 32'd1);
        arst = 1'b1;
        step(1'b1, 32'hA2, 1'b1, 1'b1);
        arst = 1'b0;
        chk_idle("midpkt reset");
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_idle("post reset");

        // 65536 single-beat packets wrap the counter
        begin
            int busy_hits = 0;
            for (int i = 0; i < 65536; i++) begin
                step(1'b1, 32'(i), 1'b1, 1'b1);
                if (busy) busy_hits++;
                if (i == 65534) chk("pkt before wrap", 32'(pkt_cnt), 32'hFFFF);
            end
            chk("wrap busy cycles", 32'(busy_hits), 32'd0);
            chk("pkt wrapped", 32'(pkt_cnt), 32'd0);
            chk("wrap level", 32'(level), 32'd1);
            chk("wrap data", out_data, 32'd65535);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
